// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    RX   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic MODE_TX = 1'b0;
  localparam logic MODE_RX = 1'b1;

  // Bits needed for a counter that reaches the full word width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit parallel-load / shift-left register with synchronous clear.
module shift_reg_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  // Register update: clear beats load beats shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], shift_in};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer: transmit a parallel word serially MSB first, or
// collect WIDTH serial bits into a word, with a valid/ready result.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic             ser_in_valid,
  output logic             ser_out,
  output logic             ser_out_valid,
  input  logic             abort,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] echo_q;
  logic             mode_q;
  logic             accept;
  logic             core_load, core_clear, core_shift, core_shift_in;
  logic [WIDTH-1:0] core_q;

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (core_load),
    .load_data (cmd_data),
    .shift_en  (core_shift),
    .shift_in  (core_shift_in),
    .clear     (core_clear),
    .q         (core_q)
  );

  // State and bit counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mode and echo latch, captured when a command is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_TX;
      echo_q <= '0;
    end else if (accept) begin
      mode_q <= cmd_mode;
      if (cmd_mode == MODE_TX) begin
        echo_q <= cmd_data;
      end
    end
  end

  // Next-state, counter and register-control decode.
  // Abort is applied last so it overrides every transition out of a busy state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    core_load  = 1'b0;
    core_clear = 1'b0;
    core_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_mode == MODE_TX) begin
            core_load = 1'b1;
            state_d   = TX;
          end else begin
            core_clear = 1'b1;
            state_d    = RX;
          end
        end
      end
      TX: begin
        core_shift = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RESP;
        end
      end
      RX: begin
        if (ser_in_valid) begin
          core_shift = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      core_shift = 1'b0;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    core_shift_in = (state_q == RX) ? ser_in : 1'b0;
    cmd_ready     = (state_q == IDLE);
    busy          = (state_q != IDLE);
    ser_out_valid = (state_q == TX);
    ser_out       = (state_q == TX) ? core_q[WIDTH-1] : 1'b0;
    rsp_valid     = (state_q == RESP);
    rsp_data      = '0;
    if (state_q == RESP) begin
      rsp_data = (mode_q == MODE_TX) ? echo_q : core_q;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl with WIDTH=4.
module tb_shift_seq_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [WIDTH-1:0] cmd_data;
  logic             ser_in;
  logic             ser_in_valid;
  logic             ser_out;
  logic             ser_out_valid;
  logic             abort;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ready;
  logic             busy;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_data      (cmd_data),
    .ser_in        (ser_in),
    .ser_in_valid  (ser_in_valid),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid),
    .abort         (abort),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sov"}, 32'(ser_out_valid), 32'd0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic issue(input logic mode, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_data  = '0;
  endtask

  // Transmit a word and check every bit plus the echo response.
  task automatic tx_word(input string tag, input logic [WIDTH-1:0] word);
    logic [WIDTH-1:0] w;
    w = word;
    rsp_ready = 1'b1;
    issue(1'b0, word);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      chk({tag, "_sov"}, 32'(ser_out_valid), 32'd1);
      chk({tag, "_bit"}, 32'(ser_out), 32'(w[i]));
      chk({tag, "_rdy_busy"}, 32'(cmd_ready), 32'd0);
      step();
    end
    chk({tag, "_sov_end"}, 32'(ser_out_valid), 32'd0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rspd"}, 32'(rsp_data), 32'(word));
    step();
    chk_idle({tag, "_after"});
  endtask

  // Feed a word with no gaps; leaves the DUT in RESP with the result checked.
  task automatic rx_word(input string tag, input logic [WIDTH-1:0] word);
    logic [WIDTH-1:0] w;
    w = word;
    issue(1'b1, '0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      chk({tag, "_rspv_pre"}, 32'(rsp_valid), 32'd0);
      ser_in       = w[i];
      ser_in_valid = 1'b1;
      step();
    end
    ser_in_valid = 1'b0;
    ser_in       = 1'b0;
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rspd"}, 32'(rsp_data), 32'(word));
  endtask

  initial begin
    reset        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_mode     = 1'b0;
    cmd_data     = '0;
    ser_in       = 1'b0;
    ser_in_valid = 1'b0;
    abort        = 1'b0;
    rsp_ready    = 1'b0;

    // Reset state
    #2;
    chk_idle("reset");
    chk("reset_so", 32'(ser_out), 32'd0);
    chk("reset_rspd", 32'(rsp_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_idle("idle");

    // Transmit 1011
    tx_word("tx1011", 4'b1011);

    // Receive 0,1,1,0 with gaps of 0, 2, 1 cycles
    rsp_ready = 1'b1;
    issue(1'b1, 4'b1111);
    chk("rx_state_busy", 32'(busy), 32'd1);
    chk("rx_no_sov", 32'(ser_out_valid), 32'd0);
    ser_in = 1'b0; ser_in_valid = 1'b1; step();
    ser_in = 1'b1; ser_in_valid = 1'b1; step();
    ser_in = 1'b0; ser_in_valid = 1'b0; step();
    ser_in = 1'b1;                      step();
    chk("rx_gap_rspv", 32'(rsp_valid), 32'd0);
    ser_in = 1'b1; ser_in_valid = 1'b1; step();
    ser_in = 1'b1; ser_in_valid = 1'b0; step();
    chk("rx_gap2_rspv", 32'(rsp_valid), 32'd0);
    ser_in = 1'b0; ser_in_valid = 1'b1; step();
    ser_in_valid = 1'b0;
    chk("rx0110_rspv", 32'(rsp_valid), 32'd1);
    chk("rx0110_rspd", 32'(rsp_data), 32'h6);
    step();
    chk_idle("rx0110_after");

    // Backpressure on receive 1100
    rsp_ready = 1'b0;
    rx_word("bp1100", 4'b1100);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rspv_hold", 32'(rsp_valid), 32'd1);
      chk("bp_rspd_hold", 32'(rsp_data), 32'hC);
      chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk_idle("bp_release");

    // Abort on the second transmitted bit of 1111
    issue(1'b0, 4'b1111);
    chk("ab_bit1_sov", 32'(ser_out_valid), 32'd1);
    step();
    chk("ab_bit2_sov", 32'(ser_out_valid), 32'd1);
    chk("ab_bit2", 32'(ser_out), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("ab_after");
    step();
    chk("ab_no_rsp", 32'(rsp_valid), 32'd0);
    tx_word("tx0001", 4'b0001);

    // Reset mid-receive after two bits
    issue(1'b1, '0);
    ser_in = 1'b1; ser_in_valid = 1'b1; step();
    ser_in = 1'b1; ser_in_valid = 1'b1; step();
    ser_in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_rspd", 32'(rsp_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_idle("rst_release");
    rsp_ready = 1'b1;
    rx_word("rx1001", 4'b1001);
    step();
    chk_idle("rx1001_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
